// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited word reads to
// instruction memory and buffers in-order responses in a small FIFO for Decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        validD,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  input  logic        stallD,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fpcQ, fpcNext;
  logic [31:0]   rpcQ, rpcNext;
  logic [CW-1:0] outstandingQ, outstandingNext;
  logic [CW-1:0] discardQ, discardNext;
  logic [CW-1:0] countQ, countNext;
  logic [PW-1:0] rdPtrQ, rdPtrNext;
  logic [PW-1:0] wrPtrQ, wrPtrNext;

  logic [31:0] instrMem [DEPTH];
  logic [31:0] pcMem    [DEPTH];

  logic        pop, issue, push, dropResp;
  logic [CW:0] creditsUsed;

  assign validD = (countQ != '0);
  assign pop    = validD & ~stallD & ~redirect;

  // Every granted request owns a FIFO slot, so a returning response can always be pushed.
  assign creditsUsed = (CW+1)'(outstandingQ) + (CW+1)'(countQ) - (CW+1)'(pop);
  assign imem_req    = rst & ~redirect & (creditsUsed < (CW+1)'(DEPTH));
  assign imem_addr   = fpcQ;
  assign issue       = imem_req & imem_gnt;

  assign dropResp = imem_rvalid & (redirect | (discardQ != '0));
  assign push     = imem_rvalid & ~dropResp;

  assign instrD = validD ? instrMem[rdPtrQ] : '0;
  assign pcD    = validD ? pcMem[rdPtrQ]    : '0;

  always_comb begin
    fpcNext         = fpcQ;
    rpcNext         = rpcQ;
    outstandingNext = outstandingQ + CW'(issue) - CW'(imem_rvalid);
    discardNext     = discardQ;
    countNext       = countQ + CW'(push) - CW'(pop);
    rdPtrNext       = rdPtrQ;
    wrPtrNext       = wrPtrQ;
    if (issue) fpcNext = fpcQ + 32'd4;
    if (push) begin
      rpcNext   = rpcQ + 32'd4;
      wrPtrNext = wrPtrQ + PW'(1);
    end
    if (pop) rdPtrNext = rdPtrQ + PW'(1);
    if (imem_rvalid && (discardQ != '0)) discardNext = discardQ - CW'(1);
    // Redirect wins: everything still in flight, including a same-cycle response, is dropped.
    if (redirect) begin
      fpcNext     = redirect_pc & 32'hFFFF_FFFC;
      rpcNext     = redirect_pc & 32'hFFFF_FFFC;
      discardNext = outstandingQ - CW'(imem_rvalid);
      countNext   = '0;
      rdPtrNext   = '0;
      wrPtrNext   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpcQ         <= RESET_PC;
      rpcQ         <= RESET_PC;
      outstandingQ <= '0;
      discardQ     <= '0;
      countQ       <= '0;
      rdPtrQ       <= '0;
      wrPtrQ       <= '0;
    end else begin
      fpcQ         <= fpcNext;
      rpcQ         <= rpcNext;
      outstandingQ <= outstandingNext;
      discardQ     <= discardNext;
      countQ       <= countNext;
      rdPtrQ       <= rdPtrNext;
      wrPtrQ       <= wrPtrNext;
    end
  end

  // Storage needs no reset: outputs are gated by validD.
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtrQ] <= imem_rdata;
      pcMem[wrPtrQ]    <= rpcQ;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: variable-latency memory, queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0200;
  localparam logic [31:0] XMASK    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        validD;
  logic [31:0] instrD, pcD;
  logic        stallD = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .validD(validD), .instrD(instrD), .pcD(pcD),
    .stallD(stallD), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: in-order responses, random latency latMin..latMax cycles after grant.
  typedef struct {
    logic [31:0] addr;
    int          ready;
  } memReq_t;
  memReq_t memQ[$];
  int lastReady = 0;
  int memReady;
  int latMin = 1, latMax = 1, gntPct = 100;

  initial forever begin
    @(negedge clk);
    if (rst && imem_req && imem_gnt) begin
      memReady = cyc + int'($urandom_range(latMax, latMin));
      if (memReady <= lastReady) memReady = lastReady + 1;
      lastReady = memReady;
      memQ.push_back('{imem_addr, memReady});
    end
  end

  task automatic driveMem();
    if (rst && memQ.size() != 0 && memQ[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memQ[0].addr ^ XMASK;
      void'(memQ.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt = ($urandom_range(99) < gntPct);
  endtask

  // Reference model: FIFO contents as a queue of {instr, pc}, plus plain counters.
  logic [63:0] mq[$];
  logic [31:0] fpcM = RESET_PC, rpcM = RESET_PC;
  int          outM = 0, discM = 0;
  bit          popM, reqM;
  logic [63:0] headM;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_validD", 32'(validD), 32'd0);
      check("rst_instrD", instrD, 32'd0);
      check("rst_pcD", pcD, 32'd0);
      mq.delete();
      fpcM = RESET_PC;
      rpcM = RESET_PC;
      outM = 0;
      discM = 0;
    end else begin
      popM  = (mq.size() != 0) && !stallD && !redirect;
      reqM  = !redirect && ((outM + mq.size() - int'(popM)) < int'(DEPTH));
      headM = (mq.size() != 0) ? mq[0] : 64'd0;
      check("model_imem_req", 32'(imem_req), 32'(reqM));
      if (reqM) check("model_imem_addr", imem_addr, fpcM);
      check("model_validD", 32'(validD), 32'(mq.size() != 0));
      check("model_instrD", instrD, headM[63:32]);
      check("model_pcD", pcD, headM[31:0]);
      if (redirect) begin
        if (imem_rvalid) outM--;
        discM = outM;
        mq.delete();
        fpcM = redirect_pc & 32'hFFFF_FFFC;
        rpcM = fpcM;
      end else begin
        if (popM) void'(mq.pop_front());
        if (reqM && imem_gnt) begin
          fpcM += 32'd4;
          outM++;
        end
        if (imem_rvalid) begin
          outM--;
          if (discM > 0) discM--;
          else begin
            mq.push_back({imem_rdata, rpcM});
            rpcM += 32'd4;
          end
        end
      end
    end
  end

  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    driveMem();
    stallD      = st;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst         = 1'b1;
    stallD      = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b1;
    #1;
  endtask

  task automatic redirOnRvalid(input logic [31:0] rpc, output bit fired);
    fired = 1'b0;
    for (int i = 0; i < 40 && !fired; i++) begin
      @(posedge clk);
      #1;
      driveMem();
      if (imem_rvalid) begin
        redirect    = 1'b1;
        stallD      = 1'b1;
        redirect_pc = rpc;
        fired       = 1'b1;
      end else begin
        redirect = 1'b0;
        stallD   = 1'b0;
      end
      #1;
    end
  endtask

  initial begin
    bit          fired;
    int          got;
    int          lat;
    int          stPct, rdPct;
    logic [31:0] pcExp;

    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, 32'h0);

    // Streaming with 1-cycle memory: cycle 1 is the first cycle after release.
    latMin = 1; latMax = 1; gntPct = 100;
    releaseReset();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RESET_PC);
    for (int k = 2; k <= 10; k++) begin
      step(1'b0, 1'b0, 32'h0);
      check("stream_addr", imem_addr, RESET_PC + 32'(4 * (k - 1)));
      if (k == 2) check("stream_c2_validD", 32'(validD), 32'd0);
      if (k >= 3) begin
        pcExp = RESET_PC + 32'(4 * (k - 3));
        check("stream_validD", 32'(validD), 32'd1);
        check("stream_pcD", pcD, pcExp);
        check("stream_instrD", instrD, pcExp ^ XMASK);
      end
    end

    // Stall five cycles: outputs freeze on 0x220, credits run out.
    for (int s = 1; s <= 5; s++) begin
      step(1'b1, 1'b0, 32'h0);
      check("stall_pcD", pcD, 32'h0000_0220);
      check("stall_instrD", instrD, 32'h0000_0220 ^ XMASK);
      if (s == 5) check("stall_req_dropped", 32'(imem_req), 32'd0);
    end
    for (int j = 0; j < 6; j++) begin
      step(1'b0, 1'b0, 32'h0);
      check("unstall_pcD", pcD, 32'h0000_0220 + 32'(4 * j));
    end

    // 3-cycle latency, redirect to 0x100 while three requests are outstanding.
    latMin = 3; latMax = 3;
    repeat (8) step(1'b0, 1'b0, 32'h0);
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) begin
      @(negedge clk);
      #1;
      if (outM == 3) fired = 1'b1;
      else step(1'b0, 1'b0, 32'h0);
    end
    check("outstanding3_reached", 32'(fired), 32'd1);
    step(1'b0, 1'b1, 32'h0000_0100);
    got = 0;
    for (int i = 1; i <= 20 && got == 0; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (i == 1) begin
        check("redir_next_validD", 32'(validD), 32'd0);
        check("redir_next_req", 32'(imem_req), 32'd1);
        check("redir_next_addr", imem_addr, 32'h0000_0100);
      end
      if (validD) begin
        got = i;
        check("redir_first_pcD", pcD, 32'h0000_0100);
        check("redir_first_instrD", instrD, 32'h0000_0100 ^ XMASK);
      end
    end
    check("redir_to_valid_latency", 32'(got), 32'd5);

    // Redirect coinciding with a response and a stall; low address bits ignored.
    latMin = 2; latMax = 2;
    repeat (6) step(1'b0, 1'b0, 32'h0);
    redirOnRvalid(32'h0000_0303, fired);
    check("rv_redir_fired", 32'(fired), 32'd1);
    step(1'b0, 1'b0, 32'h0);
    check("rv_redir_validD", 32'(validD), 32'd0);
    check("rv_redir_req", 32'(imem_req), 32'd1);
    check("rv_redir_addr", imem_addr, 32'h0000_0300);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      if (validD) begin
        got = 1;
        check("rv_redir_first_pcD", pcD, 32'h0000_0300);
      end else step(1'b0, 1'b0, 32'h0);
    end
    check("rv_redir_valid_seen", 32'(got), 32'd1);

    // Address wrap.
    latMin = 1; latMax = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    got = 0;
    for (int i = 0; i < 20 && got < 2; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (validD) begin
        check("wrap_pcD", pcD, (got == 0) ? 32'hFFFF_FFFC : 32'h0000_0000);
        check("wrap_instrD", instrD, ((got == 0) ? 32'hFFFF_FFFC : 32'h0) ^ XMASK);
        got++;
      end
    end
    check("wrap_count", 32'(got), 32'd2);

    // Randomized segments.
    for (int seg = 0; seg < 6; seg++) begin
      lat    = int'($urandom_range(4, 1));
      latMin = 1;
      latMax = lat;
      gntPct = int'($urandom_range(100, 40));
      stPct  = int'($urandom_range(50, 0));
      rdPct  = int'($urandom_range(5, 1));
      for (int c = 0; c < 400; c++) begin
        step(($urandom_range(99) < stPct), ($urandom_range(99) < rdPct), $urandom);
      end
    end

    // Asynchronous reset with the FIFO full.
    latMin = 1; latMax = 1; gntPct = 100;
    fired = 1'b0;
    for (int i = 0; i < 30 && !fired; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (mq.size() == DEPTH) fired = 1'b1;
    end
    check("fifo_full_reached", 32'(fired), 32'd1);
    check("pre_reset_validD", 32'(validD), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    memQ.delete();
    lastReady   = 0;
    imem_rvalid = 1'b0;
    #1;
    check("async_rst_req", 32'(imem_req), 32'd0);
    check("async_rst_validD", 32'(validD), 32'd0);
    check("async_rst_instrD", instrD, 32'd0);
    check("async_rst_pcD", pcD, 32'd0);
    repeat (2) @(posedge clk);
    releaseReset();
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", imem_addr, RESET_PC);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("restart_validD", 32'(validD), 32'd1);
    check("restart_pcD", pcD, RESET_PC);
    repeat (5) step(1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
